i2s_tx_master: RTL
==================

Name: i2s_tx_master

Overview:
- I2S master transmitter: takes parallel 24-bit stereo samples through a valid/ready handshake and drives BCK, LRCK and DATA with standard I2S framing.
- Format: 64 BCK per frame, 32-bit slots, MSB one BCK after the LRCK edge.
- Acts as the I2S source for the PCM1704 converter path and as a bench/loopback source feeding the I2S receiver logic from a single master clock.

Parameters:
- MCLK_DIV, 2, MCLK cycles per BCK half-period (BCK = MCLK/(2*MCLK_DIV)); legal range 1..15.
- DATA_BITS, 24, sample width per channel; legal range 16..31.
- SLOT_BITS, 32, BCK periods per channel slot; fixed at 32.

Ports:
- MCLK  in  1  master clock; sole clock domain.
- RST  in  1  synchronous active-high reset.
- ENABLE  in  1  run request; level-sensitive.
- S_LEFT  in  DATA_BITS  left sample, two's complement.
- S_RIGHT  in  DATA_BITS  right sample, two's complement.
- S_VALID  in  1  sample pair valid.
- S_READY  out  1  holding register empty; a pair is accepted when S_VALID and S_READY are both high on an MCLK edge.
- BCK  out  1  bit clock, registered.
- LRCK  out  1  word select; 0 = left, 1 = right.
- DATA  out  1  serial data, changes only with BCK falling.
- UNDERRUN  out  1  sticky flag: a frame started with no sample pair held.
- ACTIVE  out  1  high while in RUN or DRAIN.

Behaviour:
- Reset values: BCK=0, LRCK=0, DATA=0, S_READY=0 during the reset cycle and 1 after it, UNDERRUN=0, ACTIVE=0, state=IDLE, holding register empty.
- Every output is registered; all updates occur on MCLK rising edges.
- Holding register: one sample pair deep. S_READY = !full. An accept sets full.
- Frame register: loaded at each frame start from the holding register, which clears full in that same cycle. S_READY therefore rises the next cycle.
- Underrun: if full=0 at a frame start, the frame register loads zeros and UNDERRUN sets. UNDERRUN clears only on RST.
- State IDLE:
  - BCK, LRCK and DATA held at 0; counters cleared.
  - ENABLE=1 moves to RUN.
  - The frame start (load) happens in the same cycle as the transition.
  - Outputs after the transition: bit index 0, LRCK=0, DATA=0.
- State RUN, half-period counter hc:
  - hc counts 0..MCLK_DIV-1.
  - At hc=MCLK_DIV-1: hc returns to 0 and BCK toggles.
- State RUN, BCK falling (1->0 toggle):
  - The bit index b (0..63) increments.
  - In the same cycle, LRCK and DATA update for the new b.
- State RUN, bit mapping:
  - Slot s = b/32, position p = b%32.
  - LRCK = 1 for b=31..62 and 0 otherwise (LRCK leads the slot by one BCK).
  - p=1..DATA_BITS carries sample bit DATA_BITS-p (MSB first), from left for s=0 and right for s=1.
  - p=0 and p>DATA_BITS carry 0.
- State RUN, frame wrap:
  - The falling edge with b=63 -> 0 is a frame start and triggers a load.
  - If ENABLE=0 at that point, move to DRAIN instead of loading.
- ENABLE dropped mid-frame: the current frame completes; no truncation.
- State DRAIN:
  - BCK and LRCK are forced to 0 and DATA to 0.
  - Return to IDLE the next cycle.
  - ACTIVE is high in RUN and DRAIN, low in IDLE.
  - The holding register is preserved for the next RUN.
- ENABLE reasserted during DRAIN: it is honoured from IDLE on the following cycle.
- Simultaneous accept and frame start: cannot occur, because S_READY=0 while full.
- Reset mid-frame: immediately returns to reset values and discards both the holding and frame registers.
- Frame period is 128*MCLK_DIV MCLK cycles; for MCLK_DIV=2 this is 256 (MCLK = 256 fs).

Test Plan:
- Reset, then ENABLE=1 with no sample -> UNDERRUN=1 from cycle 1, DATA all zero for the full 256-cycle frame, BCK period 4 MCLK, LRCK low for b=0..30 and high for b=31..62.
- Preload L=0x800001, R=0x7FFFFE, then ENABLE=1 -> on the BCK falling edges at b=1..24 DATA reads 1,0..0,1; at b=33..56 it reads 0,1..1,0; padding bits 0; UNDERRUN stays 0.
- Hold S_VALID=1 with incrementing pairs -> exactly one accept per 256 MCLK cycles; S_READY rises the cycle after each frame start; no sample skipped or repeated.
- Deassert ENABLE at b=40 -> the frame completes to b=63, one DRAIN cycle follows, then IDLE with BCK=LRCK=DATA=0 and ACTIVE=0; a queued pair is still present on re-enable.
- Assert RST at b=20 with full=1 -> the next cycle shows all outputs at reset values and S_READY=1 after reset; the subsequent ENABLE underruns.
- MCLK_DIV=1 with DATA_BITS=16 -> BCK = MCLK/2; bits p=17..31 are zero; the frame is 128 MCLK cycles.

Source files
------------

// File: rtl/i2s_tx_master.sv
// I2S master transmitter: 64 BCK per frame, 32-bit slots, MSB one BCK after the LRCK edge.
// One-deep holding register in front of the frame register; the frame register is reloaded at every frame start.
module i2s_tx_master #(
  parameter int MCLK_DIV  = 2,
  parameter int DATA_BITS = 24,
  parameter int SLOT_BITS = 32
) (
  input  logic                 MCLK,
  input  logic                 RST,
  input  logic                 ENABLE,
  input  logic [DATA_BITS-1:0] S_LEFT,
  input  logic [DATA_BITS-1:0] S_RIGHT,
  input  logic                 S_VALID,
  output logic                 S_READY,
  output logic                 BCK,
  output logic                 LRCK,
  output logic                 DATA,
  output logic                 UNDERRUN,
  output logic                 ACTIVE
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] HC_LAST  = 4'(MCLK_DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'(2 * SLOT_BITS - 1);
  localparam logic [5:0] LR_FIRST = 6'(SLOT_BITS - 1);
  localparam logic [5:0] LR_LAST  = 6'(2 * SLOT_BITS - 2);

  state_t               state_r, state_s;
  logic [3:0]           hc_r, hc_s;
  logic [5:0]           bit_r, bit_s, bit_inc_s;
  logic [4:0]           pos_s, shamt_s;
  logic                 bck_r, bck_s, lrck_r, lrck_s, data_r, data_s;
  logic                 full_r, full_s, underrun_r, underrun_s;
  logic                 ready_r, active_r, accept_s, load_s;
  logic [DATA_BITS-1:0] hold_left_r, hold_left_s, hold_right_r, hold_right_s;
  logic [DATA_BITS-1:0] frame_left_r, frame_left_s, frame_right_r, frame_right_s;
  logic [DATA_BITS-1:0] word_s, shifted_s;

  // Next-state, serializer and holding/frame register logic.
  always_comb begin
    state_s       = state_r;
    hc_s          = hc_r;
    bit_s         = bit_r;
    bck_s         = bck_r;
    lrck_s        = lrck_r;
    data_s        = data_r;
    full_s        = full_r;
    underrun_s    = underrun_r;
    hold_left_s   = hold_left_r;
    hold_right_s  = hold_right_r;
    frame_left_s  = frame_left_r;
    frame_right_s = frame_right_r;
    load_s        = 1'b0;
    accept_s      = S_VALID && ready_r;

    // Bit mapping for the index that becomes current after a falling edge.
    bit_inc_s = bit_r + 6'd1;
    pos_s     = bit_inc_s[4:0];
    word_s    = bit_inc_s[5] ? frame_right_r : frame_left_r;
    shamt_s   = 5'(DATA_BITS) - pos_s;
    shifted_s = word_s >> shamt_s;

    case (state_r)
      ST_IDLE: begin
        hc_s   = 4'd0;
        bit_s  = 6'd0;
        bck_s  = 1'b0;
        lrck_s = 1'b0;
        data_s = 1'b0;
        if (ENABLE) begin
          state_s = ST_RUN;
          load_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (hc_r == HC_LAST) begin
          hc_s  = 4'd0;
          bck_s = !bck_r;
          if (bck_r) begin
            if (bit_r == BIT_LAST) begin
              bit_s  = 6'd0;
              lrck_s = 1'b0;
              data_s = 1'b0;
              if (ENABLE) begin
                load_s = 1'b1;
              end else begin
                state_s = ST_DRAIN;
              end
            end else begin
              bit_s  = bit_inc_s;
              lrck_s = (bit_inc_s >= LR_FIRST) && (bit_inc_s <= LR_LAST);
              if ((pos_s >= 5'd1) && (pos_s <= 5'(DATA_BITS))) begin
                data_s = shifted_s[0];
              end else begin
                data_s = 1'b0;
              end
            end
          end else begin
            bit_s = bit_r;
          end
        end else begin
          hc_s = hc_r + 4'd1;
        end
      end
      ST_DRAIN: begin
        hc_s    = 4'd0;
        bit_s   = 6'd0;
        bck_s   = 1'b0;
        lrck_s  = 1'b0;
        data_s  = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        hc_s    = 4'd0;
        bit_s   = 6'd0;
        bck_s   = 1'b0;
        lrck_s  = 1'b0;
        data_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase

    // Load happens before accept so an accept into an empty holding register survives a same-cycle load.
    if (load_s) begin
      if (full_r) begin
        frame_left_s  = hold_left_r;
        frame_right_s = hold_right_r;
        full_s        = 1'b0;
      end else begin
        frame_left_s  = '0;
        frame_right_s = '0;
        underrun_s    = 1'b1;
      end
    end else begin
      frame_left_s  = frame_left_r;
      frame_right_s = frame_right_r;
    end

    if (accept_s) begin
      hold_left_s  = S_LEFT;
      hold_right_s = S_RIGHT;
      full_s       = 1'b1;
    end else begin
      hold_left_s  = hold_left_r;
      hold_right_s = hold_right_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge MCLK) begin
    if (RST) begin
      state_r       <= ST_IDLE;
      hc_r          <= 4'd0;
      bit_r         <= 6'd0;
      bck_r         <= 1'b0;
      lrck_r        <= 1'b0;
      data_r        <= 1'b0;
      full_r        <= 1'b0;
      underrun_r    <= 1'b0;
      ready_r       <= 1'b0;
      active_r      <= 1'b0;
      hold_left_r   <= '0;
      hold_right_r  <= '0;
      frame_left_r  <= '0;
      frame_right_r <= '0;
    end else begin
      state_r       <= state_s;
      hc_r          <= hc_s;
      bit_r         <= bit_s;
      bck_r         <= bck_s;
      lrck_r        <= lrck_s;
      data_r        <= data_s;
      full_r        <= full_s;
      underrun_r    <= underrun_s;
      ready_r       <= !full_s;
      active_r      <= (state_s != ST_IDLE);
      hold_left_r   <= hold_left_s;
      hold_right_r  <= hold_right_s;
      frame_left_r  <= frame_left_s;
      frame_right_r <= frame_right_s;
    end
  end

  assign S_READY  = ready_r;
  assign BCK      = bck_r;
  assign LRCK     = lrck_r;
  assign DATA     = data_r;
  assign UNDERRUN = underrun_r;
  assign ACTIVE   = active_r;

endmodule
